// File: rtl/mem_sdp.sv
// mem_sdp: simple dual-port RAM, one write port + one read port, one clock.
// Ports: clk/rst (sync, active-high); wr/waddr/wdata/wmask write port;
// rd/raddr read request; rdata/rvalid read result; busy = clear engine on.
module mem_sdp #(
  parameter int ADDR           = 4,
  parameter int WORD           = 8,
  parameter int LANES          = 2,
  parameter int RD_LAT         = 1,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [ADDR-1:0]  waddr,
  input  logic [WORD-1:0]  wdata,
  input  logic [LANES-1:0] wmask,
  input  logic             rd,
  input  logic [ADDR-1:0]  raddr,
  output logic [WORD-1:0]  rdata,
  output logic             rvalid,
  output logic             busy
);

  localparam int DEPTH = 2 ** ADDR;
  localparam int LW    = WORD / LANES;

  logic [WORD-1:0] mem_q [DEPTH];

  logic            busy_q, busy_d;
  logic [ADDR-1:0] clr_q, clr_d;
  logic            wr_en, rd_en;
  logic [WORD-1:0] wmerge, rword;
  logic            rvalid_q;
  logic [WORD-1:0] rdata_q;

  // Requests are dropped while clearing or in reset.
  always_comb begin
    wr_en  = wr && !busy_q && !rst;
    rd_en  = rd && !busy_q && !rst;
    wmerge = mem_q[waddr];
    for (int i = 0; i < LANES; i++) begin
      if (wmask[i]) begin
        wmerge[i*LW +: LW] = wdata[i*LW +: LW];
      end
    end
    rword = mem_q[raddr];
    if (RDW_MODE != 0 && wr_en && waddr == raddr) begin
      rword = wmerge;
    end
  end

  // Clear sweep stops on the last address; the counter never wraps
  // into a second pass because busy drops on that same edge.
  always_comb begin
    busy_d = busy_q;
    clr_d  = clr_q;
    if (busy_q) begin
      clr_d = clr_q + 1'b1;
      if (clr_q == ADDR'(DEPTH - 1)) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= (CLEAR_ON_RESET != 0);
      clr_q  <= '0;
    end else begin
      busy_q <= busy_d;
      clr_q  <= clr_d;
    end
  end

  // Array has no reset; it is only touched by the sweep or a write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (busy_q) begin
        mem_q[clr_q] <= '0;
      end else if (wr_en) begin
        mem_q[waddr] <= wmerge;
      end
    end
  end

  if (RD_LAT == 1) begin : g_lat1
    always_ff @(posedge clk) begin
      if (rst) begin
        rvalid_q <= 1'b0;
        rdata_q  <= '0;
      end else begin
        rvalid_q <= rd_en;
        if (rd_en) begin
          rdata_q <= rword;
        end
      end
    end
  end else begin : g_lat2
    logic            s1_v_q;
    logic [WORD-1:0] s1_d_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        s1_v_q   <= 1'b0;
        s1_d_q   <= '0;
        rvalid_q <= 1'b0;
        rdata_q  <= '0;
      end else begin
        s1_v_q   <= rd_en;
        if (rd_en) begin
          s1_d_q <= rword;
        end
        rvalid_q <= s1_v_q;
        if (s1_v_q) begin
          rdata_q <= s1_d_q;
        end
      end
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_mem_sdp.sv
// tb_mem_sdp: three mem_sdp variants (lat1/old, lat1/new, lat2/old)
// driven in lockstep and checked against a cycle-indexed reference model.
module tb_mem_sdp;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr = 1'b0, rd = 1'b0;
  logic [3:0] waddr = '0, raddr = '0;
  logic [7:0] wdata = '0;
  logic [1:0] wmask = '0;

  logic [7:0] rdata_w [3];
  logic       rvalid_w [3];
  logic       busy_w [3];

  always #5 clk = ~clk;

  mem_sdp #(.RD_LAT(1), .RDW_MODE(0)) u_l1m0 (
    .clk(clk), .rst(rst), .wr(wr), .waddr(waddr), .wdata(wdata),
    .wmask(wmask), .rd(rd), .raddr(raddr), .rdata(rdata_w[0]),
    .rvalid(rvalid_w[0]), .busy(busy_w[0]));

  mem_sdp #(.RD_LAT(1), .RDW_MODE(1)) u_l1m1 (
    .clk(clk), .rst(rst), .wr(wr), .waddr(waddr), .wdata(wdata),
    .wmask(wmask), .rd(rd), .raddr(raddr), .rdata(rdata_w[1]),
    .rvalid(rvalid_w[1]), .busy(busy_w[1]));

  mem_sdp #(.RD_LAT(2), .RDW_MODE(0)) u_l2m0 (
    .clk(clk), .rst(rst), .wr(wr), .waddr(waddr), .wdata(wdata),
    .wmask(wmask), .rd(rd), .raddr(raddr), .rdata(rdata_w[2]),
    .rvalid(rvalid_w[2]), .busy(busy_w[2]));

  int lat  [3] = '{1, 1, 2};
  int mode [3] = '{0, 1, 0};

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] mm [16];
  int         clr_left = 0;
  int         cyc = 0;
  bit         pv [3][4096];
  logic [7:0] pd [3][4096];
  logic [7:0] last [3];
  bit         ev [3];

  function automatic logic [7:0] merge(logic [7:0] old, logic [7:0] d,
                                       logic [1:0] m);
    logic [7:0] k;
    k = {{4{m[1]}}, {4{m[0]}}};
    return (old & ~k) | (d & k);
  endfunction

  task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // Reference: memory as an array, clear as a countdown, and each read
  // scheduled to appear at (request cycle + latency - 1).
  task automatic model_edge();
    int e;
    logic [7:0] nw, v;
    e = cyc;
    if (rst) begin
      clr_left = 16;
      for (int k = 0; k < 3; k++) begin
        pv[k][e]   = 1'b0;
        pv[k][e+1] = 1'b0;
        last[k]    = 8'h00;
      end
    end else if (clr_left > 0) begin
      mm[16 - clr_left] = 8'h00;
      clr_left--;
    end else begin
      nw = merge(mm[waddr], wdata, wmask);
      if (rd) begin
        for (int k = 0; k < 3; k++) begin
          v = mm[raddr];
          if (mode[k] == 1 && wr && waddr == raddr) v = nw;
          pv[k][e + lat[k] - 1] = 1'b1;
          pd[k][e + lat[k] - 1] = v;
        end
      end
      if (wr) mm[waddr] = nw;
    end
    for (int k = 0; k < 3; k++) begin
      ev[k] = pv[k][e];
      if (ev[k]) last[k] = pd[k][e];
    end
  endtask

  task automatic step(bit r, bit w, logic [3:0] wa, logic [7:0] wd,
                      logic [1:0] wm, bit q, logic [3:0] ra);
    rst = r; wr = w; waddr = wa; wdata = wd; wmask = wm;
    rd = q; raddr = ra;
    @(posedge clk);
    model_edge();
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("busy%0d", k), {7'd0, busy_w[k]},
          {7'd0, (clr_left > 0)});
      chk($sformatf("rvalid%0d", k), {7'd0, rvalid_w[k]}, {7'd0, ev[k]});
      chk($sformatf("rdata%0d", k), rdata_w[k], last[k]);
    end
    cyc++;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic rst_step();
    step(1, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic wrt(logic [3:0] a, logic [7:0] d, logic [1:0] m);
    step(0, 1, a, d, m, 0, 0);
  endtask
  task automatic rdq(logic [3:0] a);
    step(0, 0, 0, 0, 0, 1, a);
  endtask
  task automatic wr_rd(logic [3:0] wa, logic [7:0] d, logic [1:0] m,
                       logic [3:0] ra);
    step(0, 1, wa, d, m, 1, ra);
  endtask

  initial begin
    bit r, w, q;
    logic [3:0] wa, ra;
    int nb;

    // clear after reset; request at clear cycle 8 must be ignored
    rst_step();
    rst_step();
    for (int i = 0; i < 16; i++) begin
      if (i == 7) wr_rd(4'd1, 8'h99, 2'b11, 4'd1);
      else idle();
    end
    for (int a = 0; a < 16; a++) rdq(4'(a));
    idle();
    idle();

    // write then readback
    wrt(4'd2, 8'hA7, 2'b11);
    wrt(4'd3, 8'h5C, 2'b11);
    rdq(4'd2);
    rdq(4'd3);
    idle();
    idle();

    // lane masks
    wrt(4'd2, 8'h3B, 2'b01);
    rdq(4'd2);
    idle();
    wrt(4'd2, 8'h3B, 2'b10);
    rdq(4'd2);
    idle();
    wrt(4'd2, 8'hFF, 2'b00);
    rdq(4'd2);
    idle();
    idle();

    // read-during-write
    wr_rd(4'd5, 8'h11, 2'b11, 4'd5);
    rdq(4'd5);
    idle();
    idle();

    // reset collides with a read
    wrt(4'd15, 8'hFF, 2'b11);
    step(1, 0, 0, 0, 0, 1, 4'd15);
    nb = 0;
    for (int i = 0; i < 16; i++) begin
      idle();
      if (busy_w[0]) nb++;
    end
    chk("busy_len", 8'(nb), 8'd15);
    rdq(4'd15);
    idle();
    idle();

    // reset mid-clear restarts the sweep
    rst_step();
    for (int i = 0; i < 4; i++) idle();
    rst_step();
    nb = 1;
    for (int i = 0; i < 20; i++) begin
      idle();
      if (busy_w[0]) nb++;
    end
    chk("busy_restart", 8'(nb), 8'd16);

    // latency-2 single read and hold
    wrt(4'd2, 8'hA7, 2'b11);
    rdq(4'd2);
    idle();
    idle();
    idle();

    // randomized traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 63) == 0);
      w  = 1'($urandom_range(0, 1));
      q  = 1'($urandom_range(0, 1));
      wa = 4'($urandom_range(0, 15));
      ra = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
      step(r, w, wa, 8'($urandom_range(0, 255)),
           2'($urandom_range(0, 3)), q, ra);
    end
    idle();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
